mem_io_responder: RTL and testbench
===================================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2, SHALL set the idle cycles between request acceptance and response (legal 0..15).
REQ-002 Parameter DEPTH_LOG2, default 8, SHALL set internal RAM depth to 2**DEPTH_LOG2 16-bit words.
REQ-003 Parameter IO_ADDR, default 16'hFFFF, SHALL set the single memory-mapped I/O address.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Clk  input  1  system clock, all state on rising edge.
REQ-006 Reset_n  input  1  asynchronous active-low reset.
REQ-007 Mem_Req  input  1  CPU request, held high until Mem_Ready seen.
REQ-008 Mem_WE  input  1  1 = write, 0 = read; sampled with request.
REQ-009 ADDR  input  16  word address; sampled with request.
REQ-010 Data_from_CPU  input  16  write data; sampled with request.
REQ-011 SW  input  10  board switches, read via IO_ADDR.
REQ-012 Data_to_CPU  output  16  read data, registered.
REQ-013 Mem_Ready  output  1  one-cycle completion pulse.
REQ-014 HEX_Data  output  16  display register, written via IO_ADDR.
REQ-015 Busy  output  1  high whenever FSM is not IDLE.

Function
REQ-016 FSM SHALL have states IDLE, WAIT, RESP.
REQ-017 In IDLE with Mem_Req=1 the block SHALL latch ADDR, Mem_WE, Data_from_CPU and go to WAIT (WAIT_STATES>0, counter loaded WAIT_STATES-1) or RESP (WAIT_STATES=0).
REQ-018 In WAIT the counter SHALL decrement each cycle; at count 0 the FSM SHALL go to RESP.
REQ-019 In RESP Mem_Ready SHALL be 1 for exactly one cycle, then FSM SHALL return to IDLE.
REQ-020 Latency: request sampled at edge N SHALL give Mem_Ready high in the cycle after edge N+WAIT_STATES+1.
REQ-021 A new request SHALL NOT be accepted in the RESP cycle; earliest acceptance is the first IDLE cycle after it.
REQ-022 Read, latched address = IO_ADDR: Data_to_CPU SHALL load {6'b0, SW} (SW sampled in RESP cycle) coincident with Mem_Ready.
REQ-023 Read, other address: Data_to_CPU SHALL load RAM[ADDR[DEPTH_LOG2-1:0]] coincident with Mem_Ready.
REQ-024 Write to IO_ADDR SHALL update HEX_Data in the RESP cycle and SHALL NOT modify RAM.
REQ-025 Write to other address SHALL update RAM[ADDR[DEPTH_LOG2-1:0]] in the RESP cycle; upper address bits SHALL be ignored (aliasing wrap-around).
REQ-026 Data_to_CPU SHALL hold its last value on writes and between transactions.
REQ-027 Mem_Req deasserting during WAIT SHALL NOT abort; the transaction SHALL complete and Mem_Ready pulse.
REQ-028 Changes on ADDR/Mem_WE/Data_from_CPU after acceptance SHALL have no effect on the current transaction.

Reset
REQ-029 Reset_n=0 SHALL immediately force FSM=IDLE, counter=0, Mem_Ready=0, Busy=0, Data_to_CPU=16'h0000, HEX_Data=16'h0000.
REQ-030 Reset mid-transaction SHALL abandon it with no RAM or HEX_Data write and no Mem_Ready pulse.
REQ-031 RAM contents SHALL NOT be reset.

Structure
REQ-032 State enum type (IDLE, WAIT, RESP) and default IO_ADDR constant SHALL live in the shared slc3 package.
REQ-033 RAM SHALL be one sub-module, sync_ram16, single port, synchronous write, combinational read.

Verification
REQ-034 Write 16'h1234 to 16'h0005, read 16'h0005 -> Data_to_CPU=16'h1234, Mem_Ready 3 cycles after acceptance (WAIT_STATES=2).
REQ-035 SW=10'h014, read 16'hFFFF -> Data_to_CPU=16'h0014; write 16'hBEEF to 16'hFFFF -> HEX_Data=16'hBEEF, RAM[8'hFF] unchanged.
REQ-036 Write 16'hAAAA to 16'h0105 (DEPTH_LOG2=8), read 16'h0005 -> 16'hAAAA (aliasing).
REQ-037 Reset_n pulsed low during WAIT of write 16'h5555 to 16'h0010 -> no Mem_Ready, RAM[16'h0010] unchanged, outputs zero.
REQ-038 Mem_Req held high across back-to-back reads (WAIT_STATES=0) -> Mem_Ready every 2nd cycle, never in consecutive cycles.

Source files
------------

// File: rtl/slc3_pkg.sv
// Shared types and constants for the SLC-3 memory/I-O responder slice.
package slc3_pkg;

  // Responder FSM states: waiting for a request, burning wait states, answering.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Default word address that maps to the switches (read) and hex display (write).
  localparam logic [15:0] DEFAULT_IO_ADDR = 16'hFFFF;

endpackage

// File: rtl/sync_ram16.sv
// Single-port 16-bit word RAM: synchronous write, combinational read, no reset.
module sync_ram16 #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata
);

  logic [15:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Store the write word on the rising edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_io_responder.sv
// Memory / memory-mapped I/O responder: accepts one CPU request at a time,
// waits WAIT_STATES cycles, then answers from RAM or the switch/hex I/O port.
module mem_io_responder
  import slc3_pkg::*;
#(
  parameter int          WAIT_STATES = 2,
  parameter int          DEPTH_LOG2  = 8,
  parameter logic [15:0] IO_ADDR     = DEFAULT_IO_ADDR
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Mem_Req,
  input  logic        Mem_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic [9:0]  SW,
  output logic [15:0] Data_to_CPU,
  output logic        Mem_Ready,
  output logic [15:0] HEX_Data,
  output logic        Busy
);

  // Counter preload so that exactly WAIT_STATES cycles are spent in WAIT.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  mem_state_t  state;
  logic [3:0]  wait_cnt;
  logic        lat_we;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        is_io;
  logic        ram_we;
  logic [15:0] ram_rdata;

  // The I/O decode compares the full address; RAM only sees the low bits, so upper bits alias.
  assign is_io  = (lat_addr == IO_ADDR);
  assign ram_we = (state == RESP) && lat_we && !is_io;
  assign Busy   = (state != IDLE);

  sync_ram16 #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (Clk),
    .we   (ram_we),
    .addr (lat_addr[DEPTH_LOG2-1:0]),
    .wdata(lat_wdata),
    .rdata(ram_rdata)
  );

  // Request FSM: latch the request, count wait states, then deliver a one-cycle ready pulse with data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      lat_we      <= 1'b0;
      lat_addr    <= 16'h0000;
      lat_wdata   <= 16'h0000;
      Mem_Ready   <= 1'b0;
      Data_to_CPU <= 16'h0000;
      HEX_Data    <= 16'h0000;
    end else begin
      Mem_Ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Mem_Req) begin
            lat_we    <= Mem_WE;
            lat_addr  <= ADDR;
            lat_wdata <= Data_from_CPU;
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          Mem_Ready <= 1'b1;
          state     <= IDLE;
          if (!lat_we) begin
            Data_to_CPU <= is_io ? {6'b000000, SW} : ram_rdata;
          end else if (is_io) begin
            HEX_Data <= lat_wdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed vector table, reset and
// back-to-back sequences, then randomized traffic against a transaction-level model.
module tb_mem_io_responder;

  localparam int          WS = 2;
  localparam logic [15:0] IO = 16'hFFFF;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [9:0]  sw;
    logic [15:0] exp_data;
    logic [15:0] exp_hex;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;

  logic        mem_req = 1'b0, mem_we = 1'b0;
  logic [15:0] addr = 16'h0, wdata = 16'h0;
  logic [9:0]  sw = 10'h0;
  logic [15:0] rdata, hex;
  logic        ready, busy;

  logic        z_req = 1'b0, z_we = 1'b0;
  logic [15:0] z_addr = 16'h0, z_wdata = 16'h0;
  logic [9:0]  z_sw = 10'h0;
  logic [15:0] z_rdata, z_hex;
  logic        z_ready, z_busy;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: architectural state seen by the CPU.
  logic [15:0] ref_ram [256];
  logic [15:0] ref_hex  = 16'h0000;
  logic [15:0] ref_data = 16'h0000;

  always #5 Clk = ~Clk;

  mem_io_responder #(.WAIT_STATES(WS), .DEPTH_LOG2(8), .IO_ADDR(IO)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Mem_Req(mem_req), .Mem_WE(mem_we),
    .ADDR(addr), .Data_from_CPU(wdata), .SW(sw), .Data_to_CPU(rdata),
    .Mem_Ready(ready), .HEX_Data(hex), .Busy(busy)
  );

  mem_io_responder #(.WAIT_STATES(0), .DEPTH_LOG2(8), .IO_ADDR(IO)) dut_z (
    .Clk(Clk), .Reset_n(Reset_n), .Mem_Req(z_req), .Mem_WE(z_we),
    .ADDR(z_addr), .Data_from_CPU(z_wdata), .SW(z_sw), .Data_to_CPU(z_rdata),
    .Mem_Ready(z_ready), .HEX_Data(z_hex), .Busy(z_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One full CPU transaction on the WS-wait instance; checks timing, updates the model.
  task automatic applyStimulus(input logic we_i, input logic [15:0] a, input logic [15:0] d,
                               input logic [9:0] sw_val, input bit rand_sw, input bit hold,
                               input string tag, output logic [15:0] got_data,
                               output logic [15:0] got_hex);
    int          lat;
    logic [15:0] sw_resp;
    logic        busy_acc, busy_end;
    mem_req = 1'b1; mem_we = we_i; addr = a; wdata = d;
    sw = rand_sw ? 10'($urandom) : sw_val;
    @(posedge Clk); #1;
    busy_acc = busy;
    if (!hold) mem_req = 1'b0;
    mem_we = 1'($urandom_range(0, 1));
    addr   = 16'($urandom);
    wdata  = 16'($urandom);
    lat = 0;
    sw_resp = 16'h0;
    for (int k = 0; k < 40; k++) begin
      if (rand_sw) sw = 10'($urandom);
      sw_resp = {6'b000000, sw};
      @(posedge Clk); #1;
      lat++;
      if (ready) break;
    end
    mem_req  = 1'b0;
    got_data = rdata;
    got_hex  = hex;
    busy_end = busy;
    if (we_i) begin
      if (a == IO) ref_hex = d;
      else ref_ram[a[7:0]] = d;
    end else begin
      ref_data = (a == IO) ? sw_resp : ref_ram[a[7:0]];
    end
    checkOutput($sformatf("%s latency", tag), lat, WS + 1);
    checkOutput($sformatf("%s busy after accept", tag), {31'b0, busy_acc}, 32'd1);
    checkOutput($sformatf("%s busy at ready", tag), {31'b0, busy_end}, 32'd0);
    @(posedge Clk); #1;
    checkOutput($sformatf("%s ready one cycle", tag), {31'b0, ready}, 32'd0);
  endtask

  initial begin
    vec_t        vecs[10];
    logic [15:0] gd, gh;
    int          seen, consec;
    logic        prev;
    logic        we_r;
    logic [15:0] a_r;

    vecs[0] = '{1'b1, 16'h0005, 16'h1234, 10'h000, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 16'h0005, 16'h0000, 10'h000, 16'h1234, 16'h0000};
    vecs[2] = '{1'b0, 16'hFFFF, 16'h0000, 10'h014, 16'h0014, 16'h0000};
    vecs[3] = '{1'b1, 16'h00FF, 16'h7777, 10'h000, 16'h0014, 16'h0000};
    vecs[4] = '{1'b1, 16'hFFFF, 16'hBEEF, 10'h000, 16'h0014, 16'hBEEF};
    vecs[5] = '{1'b0, 16'h00FF, 16'h0000, 10'h000, 16'h7777, 16'hBEEF};
    vecs[6] = '{1'b1, 16'h0105, 16'hAAAA, 10'h000, 16'h7777, 16'hBEEF};
    vecs[7] = '{1'b0, 16'h0005, 16'h0000, 10'h000, 16'hAAAA, 16'hBEEF};
    vecs[8] = '{1'b1, 16'hFFFF, 16'h0042, 10'h000, 16'hAAAA, 16'h0042};
    vecs[9] = '{1'b0, 16'hFFFF, 16'h0000, 10'h3FF, 16'h03FF, 16'h0042};

    // Power-on reset: outputs must clear without waiting for a clock edge.
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("reset ready", {31'b0, ready}, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset data", {16'b0, rdata}, 32'h0);
    checkOutput("reset hex", {16'b0, hex}, 32'h0);
    checkOutput("reset z ready", {31'b0, z_ready}, 32'd0);
    checkOutput("reset z data", {16'b0, z_rdata}, 32'h0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sw, 1'b0, (i % 2) == 1,
                    $sformatf("vec%0d", i), gd, gh);
      checkOutput($sformatf("vec%0d data", i), {16'b0, gd}, {16'b0, vecs[i].exp_data});
      checkOutput($sformatf("vec%0d hex", i), {16'b0, gh}, {16'b0, vecs[i].exp_hex});
    end

    // Zero-wait instance with request held: ready every second cycle, never twice in a row.
    z_sw = 10'h155; z_we = 1'b0; z_addr = IO; z_req = 1'b1;
    prev = 1'b0; consec = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge Clk); #1;
      checkOutput($sformatf("b2b ready edge%0d", k), {31'b0, z_ready}, {31'b0, (k % 2) == 0});
      if (z_ready && prev) consec++;
      if (z_ready) checkOutput($sformatf("b2b data edge%0d", k), {16'b0, z_rdata}, 32'h0155);
      prev = z_ready;
    end
    z_req = 1'b0;
    checkOutput("b2b consecutive ready", consec, 0);

    // Reset during WAIT abandons the write and produces no ready pulse.
    applyStimulus(1'b1, 16'h0010, 16'h1111, 10'h0, 1'b0, 1'b0, "pre-reset write", gd, gh);
    mem_req = 1'b1; mem_we = 1'b1; addr = 16'h0010; wdata = 16'h5555;
    @(posedge Clk); #1;
    mem_req = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    #1;
    checkOutput("midreset ready", {31'b0, ready}, 32'd0);
    checkOutput("midreset busy", {31'b0, busy}, 32'd0);
    checkOutput("midreset data", {16'b0, rdata}, 32'h0);
    checkOutput("midreset hex", {16'b0, hex}, 32'h0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    ref_hex = 16'h0000; ref_data = 16'h0000;
    seen = 0;
    repeat (6) begin
      @(posedge Clk); #1;
      if (ready) seen++;
    end
    checkOutput("midreset no ready", seen, 0);
    applyStimulus(1'b0, 16'h0010, 16'h0, 10'h0, 1'b0, 1'b0, "post-reset read", gd, gh);
    checkOutput("post-reset ram kept", {16'b0, gd}, 32'h1111);
    checkOutput("post-reset hex", {16'b0, gh}, 32'h0);

    // Fill every RAM word through aliased addresses so later reads are all defined.
    for (int i = 0; i < 256; i++) begin
      a_r = {8'($urandom_range(0, 254)), 8'(i)};
      applyStimulus(1'b1, a_r, 16'($urandom), 10'h0, 1'b1, 1'($urandom_range(0, 1)),
                    $sformatf("fill%0d", i), gd, gh);
      checkOutput($sformatf("fill%0d data hold", i), {16'b0, gd}, {16'b0, ref_data});
      checkOutput($sformatf("fill%0d hex", i), {16'b0, gh}, {16'b0, ref_hex});
    end

    // Randomized traffic against the model, with occasional I/O accesses.
    for (int i = 0; i < 150; i++) begin
      we_r = 1'($urandom_range(0, 1));
      a_r  = ($urandom_range(0, 7) == 0) ? IO : 16'($urandom);
      applyStimulus(we_r, a_r, 16'($urandom), 10'h0, 1'b1, 1'($urandom_range(0, 1)),
                    $sformatf("rand%0d", i), gd, gh);
      checkOutput($sformatf("rand%0d data", i), {16'b0, gd}, {16'b0, ref_data});
      checkOutput($sformatf("rand%0d hex", i), {16'b0, gh}, {16'b0, ref_hex});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
